// File: rtl/uart.sv
// ---------------------------------------------------------------------------
// uart
// Minimal 8N1 UART transceiver with a 4-bit user data path. The transmitter
// sends {4'b0000, data_in} as one frame. The receiver deserializes frames from
// rx and shows the low nibble of the last good byte on the LEDs and on an
// active-low 7-segment display.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rstn         asynchronous active-low reset
//   data_in[3:0] nibble to transmit, sampled when a frame starts
//   data_en      transmit enable (level; held high gives back-to-back frames)
//   tx           serial output, idle high
//   tx_busy      high while a frame is being shifted out on tx
//   rx           serial input, asynchronous to clk
//   ready        received-data-valid flag
//   ready_clr    clears ready (a simultaneous new byte wins)
//   led_out[3:0] low nibble of the last byte received with a valid stop bit
//   display_out  7-segment code of led_out, active-low {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module uart #(
    parameter int CLOCKS_PER_PULSE = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] data_in,
    input  logic       data_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       ready,
    input  logic       ready_clr,
    output logic [3:0] led_out,
    output logic [7:0] display_out
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t     tx_state, tx_state_next;
    logic [CW-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]    tx_idx, tx_idx_next;
    logic [7:0]    tx_data, tx_data_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_idx   <= tx_idx_next;
            tx_data  <= tx_data_next;
        end
    end

    // tx and tx_busy are decoded from the registered state, so busy rises on
    // the same edge that leaves IDLE and falls on the edge that returns to it.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_idx_next   = tx_idx;
        tx_data_next  = tx_data;
        tx            = 1'b1;
        tx_busy       = (tx_state != TX_IDLE);

        case (tx_state)
            TX_IDLE: begin
                if (data_en) begin
                    tx_data_next  = {4'b0000, data_in};
                    tx_cnt_next   = '0;
                    tx_idx_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                tx = tx_data[tx_idx];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_idx == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_idx_next = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                tx = 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver input synchronizer (reset to idle-high so a reset does not
    // look like a start bit)
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t     rx_state, rx_state_next;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]    rx_idx, rx_idx_next;
    logic [7:0]    rx_shift, rx_shift_next;
    logic          rx_err, rx_err_next;
    logic          byte_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_idx   <= rx_idx_next;
            rx_shift <= rx_shift_next;
            rx_err   <= rx_err_next;
        end
    end

    // START waits half a bit so every later sample lands near a bit center.
    // rx_err marks a bad stop bit: the byte is dropped and the FSM parks in
    // STOP until the line returns high, so a held-low line cannot retrigger.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_idx_next   = rx_idx;
        rx_shift_next = rx_shift;
        rx_err_next   = rx_err;
        byte_done     = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                rx_idx_next = '0;
                rx_err_next = 1'b0;
                if (!rx_sync) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_idx_next = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_err) begin
                    if (rx_sync) begin
                        rx_err_next   = 1'b0;
                        rx_state_next = RX_IDLE;
                    end
                end else if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_sync) begin
                        byte_done     = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_err_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            default: begin
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    // A completed byte takes priority over ready_clr on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready   <= 1'b0;
            led_out <= '0;
        end else begin
            if (byte_done) begin
                ready   <= 1'b1;
                led_out <= rx_shift[3:0];
            end else if (ready_clr) begin
                ready <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // 7-segment decode, active-low {dp,g,f,e,d,c,b,a}, dp always off
    // ------------------------------------------------------------------
    always_comb begin
        display_out = 8'hC0;
        case (led_out)
            4'h0: display_out = 8'hC0;
            4'h1: display_out = 8'hF9;
            4'h2: display_out = 8'hA4;
            4'h3: display_out = 8'hB0;
            4'h4: display_out = 8'h99;
            4'h5: display_out = 8'h92;
            4'h6: display_out = 8'h82;
            4'h7: display_out = 8'hF8;
            4'h8: display_out = 8'h80;
            4'h9: display_out = 8'h90;
            4'hA: display_out = 8'h88;
            4'hB: display_out = 8'h83;
            4'hC: display_out = 8'hC6;
            4'hD: display_out = 8'hA1;
            4'hE: display_out = 8'h86;
            4'hF: display_out = 8'h8E;
            default: display_out = 8'hC0;
        endcase
    end

endmodule

// File: tb/tb_uart.sv
// ---------------------------------------------------------------------------
// tb_uart
// Bench for uart with CLOCKS_PER_PULSE=4. Every received byte the stimulus
// expects is pushed into a queue; a monitor pops an entry on each rising edge
// of ready and compares led_out and display_out against it.
// ---------------------------------------------------------------------------
module tb_uart;

    localparam int CPP = 4;

    logic       clk;
    logic       rstn;
    logic [3:0] data_in;
    logic       data_en;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       ready;
    logic       ready_clr;
    logic [3:0] led_out;
    logic [7:0] display_out;

    logic       loopback;
    logic       rx_drv;

    int checks;
    int failures;
    int ready_seen;

    typedef struct {
        logic [3:0] nib;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    assign rx = loopback ? tx : rx_drv;

    uart #(.CLOCKS_PER_PULSE(CPP)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data_in     (data_in),
        .data_en     (data_en),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .rx          (rx),
        .ready       (ready),
        .ready_clr   (ready_clr),
        .led_out     (led_out),
        .display_out (display_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic push_expected(input logic [3:0] nib);
        exp_t e;
        e.nib = nib;
        e.seg = seg_tab[nib];
        sb.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic apply_stimulus(input logic [3:0] nib, input logic en);
        data_in = nib;
        data_en = en;
    endtask

    task automatic pulse_reset();
        data_en = 1'b0;
        rstn    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wait_sb_empty(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (CPP) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (2 * CPP) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    initial begin : monitor
        logic ready_q;
        exp_t e;
        ready_q = 1'b0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && ready_q !== 1'b1) begin
                ready_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_ready led_out=%0h required=no_ready", led_out);
                end else begin
                    e = sb.pop_front();
                    check_output("sb_led_out", 32'(led_out), 32'(e.nib));
                    check_output("sb_display_out", 32'(display_out), 32'(e.seg));
                end
            end
            ready_q = ready;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic       tx_rec [60];
        int         busy_cnt;
        int         seen;
        logic [9:0] exp_bits;
        logic [3:0] got4;
        logic       idle_ok;

        checks     = 0;
        failures   = 0;
        ready_seen = 0;
        loopback   = 1'b1;
        rx_drv     = 1'b1;
        ready_clr  = 1'b1;
        rstn       = 1'b0;
        apply_stimulus(4'h0, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_tx", 32'(tx), 32'h1);
        check_output("reset_tx_busy", 32'(tx_busy), 32'h0);
        check_output("reset_ready", 32'(ready), 32'h0);
        check_output("reset_led_out", 32'(led_out), 32'h0);
        check_output("reset_display_out", 32'(display_out), 32'hC0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Loopback of every nonzero nibble
        $display("[TB] loopback 1..F");
        for (int d = 1; d < 16; d++) begin
            pulse_reset();
            push_expected(4'(d));
            apply_stimulus(4'(d), 1'b1);
            wait_sb_empty(200, $sformatf("loopback_%0h", d));
        end

        // Frame timing for 5, with data_in changed while busy
        $display("[TB] frame timing");
        pulse_reset();
        push_expected(4'h5);
        apply_stimulus(4'h5, 1'b1);
        @(posedge clk);
        #1 apply_stimulus(4'hC, 1'b0);
        busy_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            tx_rec[j] = tx;
            if (tx_busy === 1'b1) busy_cnt++;
        end
        exp_bits = 10'b1000001010;
        for (int k = 0; k < 10; k++) begin
            got4 = {tx_rec[4*k+3], tx_rec[4*k+2], tx_rec[4*k+1], tx_rec[4*k]};
            check_output($sformatf("tx_bit_%0d", k), 32'(got4), 32'({4{exp_bits[k]}}));
        end
        idle_ok = 1'b1;
        for (int j = 40; j < 60; j++) begin
            if (tx_rec[j] !== 1'b1) idle_ok = 1'b0;
        end
        check_output("tx_idle_after_frame", 32'(idle_ok), 32'h1);
        check_output("tx_busy_cycles", 32'(busy_cnt), 32'd40);
        wait_sb_empty(100, "timing_rx");

        // ready holds without ready_clr, then clears after a 1-cycle clear
        $display("[TB] ready hold and clear");
        pulse_reset();
        ready_clr = 1'b0;
        push_expected(4'h9);
        apply_stimulus(4'h9, 1'b1);
        @(posedge clk);
        #1 apply_stimulus(4'h9, 1'b0);
        wait_sb_empty(150, "hold_rx");
        repeat (10) @(negedge clk);
        check_output("ready_held", 32'(ready), 32'h1);
        @(posedge clk);
        #1 ready_clr = 1'b1;
        @(posedge clk);
        #1 ready_clr = 1'b0;
        @(negedge clk);
        check_output("ready_cleared", 32'(ready), 32'h0);
        check_output("led_after_clear", 32'(led_out), 32'h9);
        ready_clr = 1'b1;

        // Reset in the middle of a frame (led_out still 9 from above)
        $display("[TB] mid-frame reset");
        apply_stimulus(4'h6, 1'b1);
        @(posedge clk);
        #1 apply_stimulus(4'h6, 1'b0);
        repeat (20) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check_output("midreset_tx", 32'(tx), 32'h1);
        check_output("midreset_tx_busy", 32'(tx_busy), 32'h0);
        check_output("midreset_ready", 32'(ready), 32'h0);
        check_output("midreset_led_out", 32'(led_out), 32'h0);
        check_output("midreset_display_out", 32'(display_out), 32'hC0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        seen = ready_seen;
        repeat (80) @(negedge clk);
        check_output("midreset_no_ready", 32'(ready_seen), 32'(seen));

        // Framing error, then a good frame
        $display("[TB] framing error");
        loopback = 1'b0;
        rx_drv   = 1'b1;
        pulse_reset();
        push_expected(4'h3);
        send_frame(8'h03, 1'b1);
        wait_sb_empty(50, "pre_frame_rx");
        seen = ready_seen;
        send_frame(8'h07, 1'b0);
        repeat (10) @(negedge clk);
        check_output("framing_no_ready", 32'(ready_seen), 32'(seen));
        check_output("framing_led_kept", 32'(led_out), 32'h3);
        push_expected(4'hA);
        send_frame(8'h0A, 1'b1);
        wait_sb_empty(50, "after_framing_rx");
        @(negedge clk);
        check_output("after_framing_led", 32'(led_out), 32'hA);
        check_output("after_framing_display", 32'(display_out), 32'h88);

        // One-cycle glitch while idle
        $display("[TB] rx glitch");
        seen = ready_seen;
        @(posedge clk);
        #1 rx_drv = 1'b0;
        @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check_output("glitch_no_ready", 32'(ready_seen), 32'(seen));
        check_output("glitch_led_kept", 32'(led_out), 32'hA);
        push_expected(4'hC);
        @(posedge clk);
        #1;
        send_frame(8'h0C, 1'b1);
        wait_sb_empty(50, "after_glitch_rx");

        check_output("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
